stream_merge_2to1: RTL and testbench

Two-input round-robin stream merger with a one-beat registered output stage. It sits directly downstream of the 1-to-2 demux stage and recombines its two output channels into a single stream. Each beat is tagged with the channel it came from, and per-channel accept counters are kept for debug. The output side uses a valid/ready handshake so a stalled consumer back-pressures both inputs without losing data.

---
 rtl/stream_merge_2to1.sv | 85 ++++++++
 tb/tb_stream_merge_2to1.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_merge_2to1.sv
// Two-input round-robin stream merger with a single registered output beat,
// source tagging and per-channel accept counters.
module stream_merge_2to1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             prio;
  logic             load_en;
  logic             acc0;
  logic             acc1;

  logic             out_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_src_nxt;
  logic             prio_nxt;
  logic [CNT_W-1:0] cnt0_nxt;
  logic [CNT_W-1:0] cnt1_nxt;

  // Output register can load when empty or being drained this cycle
  assign load_en   = !out_valid || out_ready;
  assign in0_ready = load_en && (!prio || !in1_valid);
  assign in1_ready = load_en && (prio || !in0_valid);
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  // Next-state: accept replaces the held beat, otherwise a drain empties it
  always_comb begin
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_src_nxt   = out_src;
    prio_nxt      = prio;
    cnt0_nxt      = cnt0;
    cnt1_nxt      = cnt1;
    if (acc0) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = in0_data;
      out_src_nxt   = 1'b0;
      prio_nxt      = 1'b1;
      cnt0_nxt      = cnt0 + CNT_W'(1);
    end else if (acc1) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = in1_data;
      out_src_nxt   = 1'b1;
      prio_nxt      = 1'b0;
      cnt1_nxt      = cnt1 + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_src   <= out_src_nxt;
      prio      <= prio_nxt;
      cnt0      <= cnt0_nxt;
      cnt1      <= cnt1_nxt;
    end
  end

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Bench for stream_merge_2to1: directed scenarios plus a randomized run
// against a queue-based scoreboard of accepted beats.
module tb_stream_merge_2to1;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in0_valid = 1'b0;
  logic [WIDTH-1:0] in0_data = '0;
  logic             in0_ready;
  logic             in1_valid = 1'b0;
  logic [WIDTH-1:0] in1_data = '0;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;

  stream_merge_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_src"},   32'(out_src), 0);
    check({tag, "_cnt0"},  32'(cnt0), 0);
    check({tag, "_cnt1"},  32'(cnt1), 0);
  endtask

  // Scoreboard state for the randomized run
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] exp0[4];
  int unsigned n0, n1;
  bit last, m_valid, pend, pend_src, hs0, hs1, ohs, e0, e1, lden, a0, a1;
  int i0, i1;

  initial begin
    // Reset state and a single in0 beat
    do_reset();
    check_cleared("reset");
    in0_valid = 1'b1; in0_data = 8'h11; out_ready = 1'b1;
    #1;
    check("t1_in0_ready", 32'(in0_ready), 1);
    tick();
    in0_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h11);
    check("t1_src", 32'(out_src), 0);
    check("t1_cnt0", 32'(cnt0), 1);
    // prio moved to in1: contention must grant in1
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    check("t1_prio_r0", 32'(in0_ready), 0);
    check("t1_prio_r1", 32'(in1_ready), 1);

    // Sustained contention alternates starting from in0
    do_reset();
    exp0[0] = 8'hA0; exp0[1] = 8'hB0; exp0[2] = 8'hA1; exp0[3] = 8'hB1;
    i0 = 0; i1 = 0;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 8'hA0 + 8'(i0);
      in1_data = 8'hB0 + 8'(i1);
      #1;
      a0 = in0_ready; a1 = in1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
      check("t2_valid", 32'(out_valid), 1);
      check("t2_data", 32'(out_data), 32'(exp0[k]));
      check("t2_src", 32'(out_src), 32'(k % 2));
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    check("t2_cnt0", 32'(cnt0), 2);
    check("t2_cnt1", 32'(cnt1), 2);

    // Stall with both inputs valid, then drain-and-replace with no bubble
    in0_valid = 1'b1; in0_data = 8'h55;
    tick();
    check("t3_load", 32'(out_data), 32'h55);
    out_ready = 1'b0; in0_data = 8'h66; in1_valid = 1'b1; in1_data = 8'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_r0", 32'(in0_ready), 0);
      check("t3_stall_r1", 32'(in1_ready), 0);
      tick();
      check("t3_hold_data", 32'(out_data), 32'h55);
      check("t3_hold_src", 32'(out_src), 0);
      check("t3_hold_cnt0", 32'(cnt0), 3);
      check("t3_hold_cnt1", 32'(cnt1), 2);
    end
    out_ready = 1'b1;
    #1;
    check("t3_drain_r0", 32'(in0_ready), 0);
    check("t3_drain_r1", 32'(in1_ready), 1);
    tick();
    check("t3_nobubble", 32'(out_valid), 1);
    check("t3_next_data", 32'(out_data), 32'h77);
    check("t3_next_src", 32'(out_src), 1);

    // Counter wrap on in1
    do_reset();
    in1_valid = 1'b1; in1_data = 8'h3C; out_ready = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    check("t4_full", 32'(cnt1), 32'hFFFF);
    check("t4_tput", 32'(out_valid), 1);
    tick();
    check("t4_wrap", 32'(cnt1), 0);
    check("t4_cnt0", 32'(cnt0), 0);

    // Reset overrides a pending in1 accept and discards the held beat
    rst_n = 1'b0;
    tick();
    check_cleared("t5");
    rst_n = 1'b1;
    in0_valid = 1'b1;
    #1;
    check("t5_prio_r0", 32'(in0_ready), 1);
    check("t5_prio_r1", 32'(in1_ready), 0);

    // Randomized run against the scoreboard
    do_reset();
    last = 1'b1; m_valid = 1'b0; pend = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 10000; c++) begin
      if (pend) begin
        check("rnd_lat_data", 32'(out_data), 32'(pend_data));
        check("rnd_lat_src", 32'(out_src), 32'(pend_src));
      end
      check("rnd_valid", 32'(out_valid), 32'(m_valid));
      check("rnd_cnt0", 32'(cnt0), 32'(CNT_W'(n0)));
      check("rnd_cnt1", 32'(cnt1), 32'(CNT_W'(n1)));
      if (!in0_valid || hs0) begin
        in0_valid = ($urandom_range(0, 99) < 60);
        in0_data = 8'($urandom);
      end
      if (!in1_valid || hs1) begin
        in1_valid = ($urandom_range(0, 99) < 60);
        in1_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      lden = !m_valid || out_ready;
      e0 = lden && in0_valid && (!in1_valid || last);
      e1 = lden && in1_valid && (!in0_valid || !last);
      hs0 = in0_valid && in0_ready;
      hs1 = in1_valid && in1_ready;
      ohs = out_valid && out_ready;
      check("rnd_grant", 32'({hs1, hs0}), 32'({e1, e0}));
      if (ohs) begin
        if (out_src) begin
          check("rnd_q1_nonempty", 32'(q1.size() != 0), 1);
          if (q1.size() != 0) begin
            exp_d = q1.pop_front();
            check("rnd_out1", 32'(out_data), 32'(exp_d));
          end
        end else begin
          check("rnd_q0_nonempty", 32'(q0.size() != 0), 1);
          if (q0.size() != 0) begin
            exp_d = q0.pop_front();
            check("rnd_out0", 32'(out_data), 32'(exp_d));
          end
        end
      end
      if (hs0 || hs1) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
      pend = hs0 || hs1;
      pend_src = hs1;
      pend_data = hs1 ? in1_data : in0_data;
      if (hs0) begin q0.push_back(in0_data); n0++; last = 1'b0; end
      if (hs1) begin q1.push_back(in1_data); n1++; last = 1'b1; end
      tick();
    end
    check("rnd_end_cnt0", 32'(cnt0), 32'(CNT_W'(n0)));
    check("rnd_end_cnt1", 32'(cnt1), 32'(CNT_W'(n1)));
    check("rnd_outstanding", 32'(q0.size() + q1.size()), 32'(m_valid));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
